// File: rtl/conf_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ configuration writers into one registered output word.
// Optional transfer counter output c_count is built when CONF_ARB_COUNT_EN is defined.
module conf_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 14
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         r_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]  r_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  r_data,
   output logic [NUM_REQ-1:0]         r_ready,
   input  logic                       c_ready,
   output logic [ADDR_W-1:0]          c_addr,
   output logic [DATA_W-1:0]          c_data,
   output logic                       c_valid,
   output logic [$clog2(NUM_REQ)-1:0] c_src
`ifdef CONF_ARB_COUNT_EN
   ,
   output logic [15:0]                c_count
`endif
);

   localparam int SRC_W = $clog2(NUM_REQ);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_nx_s;
   logic [SRC_W-1:0]   last_r;
   logic [SRC_W-1:0]   grant_idx_s;
   logic [SRC_W:0]     cand_sum_s;
   logic               grant_found_s;
   logic               accept_s;
   logic               handshake_s;
   logic [NUM_REQ-1:0] grant_s;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = '0;
      cand_sum_s    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_sum_s = {1'b0, last_r} + (SRC_W+1)'(k);
         if (cand_sum_s >= (SRC_W+1)'(NUM_REQ)) begin
            cand_sum_s = cand_sum_s - (SRC_W+1)'(NUM_REQ);
         end else begin
            cand_sum_s = cand_sum_s;
         end
         if (!grant_found_s && r_valid[cand_sum_s[SRC_W-1:0]]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_sum_s[SRC_W-1:0];
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   // Grant only when the output slot can take a word; forced idle during reset.
   always_comb begin
      accept_s    = (state_r == ST_EMPTY) || c_ready;
      handshake_s = accept_s && grant_found_s && !rst;
      grant_s     = '0;
      if (handshake_s) begin
         grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
      end else begin
         grant_s = '0;
      end
      r_ready = grant_s;
   end

   // Output slot occupancy: a new word always wins over retirement.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_EMPTY: begin
            if (handshake_s) begin
               state_nx_s = ST_FULL;
            end else begin
               state_nx_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (handshake_s) begin
               state_nx_s = ST_FULL;
            end else if (c_ready) begin
               state_nx_s = ST_EMPTY;
            end else begin
               state_nx_s = ST_FULL;
            end
         end
         default: state_nx_s = ST_EMPTY;
      endcase
   end

   // State, arbitration pointer and output word registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_EMPTY;
         last_r  <= SRC_W'(NUM_REQ - 1);
         c_addr  <= '0;
         c_data  <= '0;
         c_src   <= '0;
      end else begin
         state_r <= state_nx_s;
         if (handshake_s) begin
            last_r <= grant_idx_s;
            c_src  <= grant_idx_s;
            c_addr <= r_addr[grant_idx_s*ADDR_W +: ADDR_W];
            c_data <= r_data[grant_idx_s*DATA_W +: DATA_W];
         end
      end
   end

   assign c_valid = (state_r == ST_FULL);

`ifdef CONF_ARB_COUNT_EN
   // Completed-transfer counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_count <= 16'd0;
      end else if (c_valid && c_ready) begin
         c_count <= c_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conf_arbiter.sv
// Self-checking bench for conf_arbiter: directed vectors plus a per-cycle reference model.
module tb_conf_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 14;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        r_valid;
   logic [NUM_REQ*ADDR_W-1:0] r_addr;
   logic [NUM_REQ*DATA_W-1:0] r_data;
   logic [NUM_REQ-1:0]        r_ready;
   logic                      c_ready;
   logic [ADDR_W-1:0]         c_addr;
   logic [DATA_W-1:0]         c_data;
   logic                      c_valid;
   logic [1:0]                c_src;
`ifdef CONF_ARB_COUNT_EN
   logic [15:0]               c_count;
`endif

   int checks   = 0;
   int failures = 0;

   conf_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .r_valid (r_valid),
      .r_addr  (r_addr),
      .r_data  (r_data),
      .r_ready (r_ready),
      .c_ready (c_ready),
      .c_addr  (c_addr),
      .c_data  (c_data),
      .c_valid (c_valid),
      .c_src   (c_src)
`ifdef CONF_ARB_COUNT_EN
      ,
      .c_count (c_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: what the sink should see, advanced once per cycle.
   bit          m_full  = 1'b0;
   int          m_addr  = 0;
   int          m_data  = 0;
   int          m_src   = 0;
   int          m_last  = NUM_REQ - 1;
   logic [15:0] m_count = 16'd0;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            m_full = 1'b0; m_addr = 0; m_data = 0; m_src = 0;
            m_last = NUM_REQ - 1; m_count = 16'd0;
         end
         chk("model_c_valid", {31'd0, c_valid}, {31'd0, m_full});
         chk("model_c_addr", {28'd0, c_addr}, m_addr);
         chk("model_c_data", {18'd0, c_data}, m_data);
         chk("model_c_src", {30'd0, c_src}, m_src);
`ifdef CONF_ARB_COUNT_EN
         chk("model_c_count", {16'd0, c_count}, {16'd0, m_count});
`endif
         if (rst) begin
            chk("model_r_ready_rst", {28'd0, r_ready}, 32'd0);
         end else begin
            int g;
            int exp_rr;
            g = -1;
            for (int k = 1; k <= NUM_REQ; k++) begin
               int idx;
               idx = (m_last + k) % NUM_REQ;
               if (g < 0 && r_valid[idx]) g = idx;
            end
            exp_rr = 0;
            if ((!m_full || c_ready) && g >= 0) exp_rr = 1 << g;
            chk("model_r_ready", {28'd0, r_ready}, exp_rr);
            if (m_full && c_ready) m_count = m_count + 16'd1;
            if (exp_rr != 0) begin
               m_full = 1'b1;
               m_src  = g;
               m_last = g;
               m_addr = int'(r_addr[g*ADDR_W +: ADDR_W]);
               m_data = int'(r_data[g*DATA_W +: DATA_W]);
            end else if (m_full && c_ready) begin
               m_full = 1'b0;
            end
         end
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #2;
   endtask

   logic [3:0] exp_seq [5];

   initial begin
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst = 1'b1; r_valid = 4'b0000; c_ready = 1'b0;
      r_addr = {4'h4, 4'h3, 4'h2, 4'h1};
      r_data = {14'h0444, 14'h0333, 14'h0222, 14'h0111};
      repeat (2) @(posedge clk);
      #2; r_valid = 4'b1111; #1;
      chk("rst_r_ready", {28'd0, r_ready}, 32'd0);
      chk("rst_c_valid", {31'd0, c_valid}, 32'd0);
      chk("rst_c_addr", {28'd0, c_addr}, 32'd0);

      // All requesters busy with a free-running sink: strict rotation.
      next_cyc(); rst = 1'b0; c_ready = 1'b1; #1;
      for (int i = 0; i < 5; i++) begin
         chk("rr_grant", {28'd0, r_ready}, {28'd0, exp_seq[i]});
         if (i > 0) begin
            chk("rr_c_valid", {31'd0, c_valid}, 32'd1);
            chk("rr_c_src", {30'd0, c_src}, i - 1);
         end
         next_cyc(); #1;
      end
      chk("rr_last_data", {18'd0, c_data}, 32'h0111);
      r_addr = ~r_addr; #1;
      chk("rr_addr_indep", {28'd0, r_ready}, 32'd2);
      r_addr = ~r_addr;

      // Held word under back-pressure.
      r_valid = 4'b0000; next_cyc();
      r_addr[8 +: 4] = 4'hA; r_data[28 +: 14] = 14'h1234;
      r_valid = 4'b0100; c_ready = 1'b0; #1;
      chk("bp_grant", {28'd0, r_ready}, 32'h4);
      chk("bp_empty", {31'd0, c_valid}, 32'd0);
      next_cyc(); r_valid = 4'b1111;
      repeat (5) begin
         #1;
         chk("bp_c_valid", {31'd0, c_valid}, 32'd1);
         chk("bp_c_addr", {28'd0, c_addr}, 32'hA);
         chk("bp_c_data", {18'd0, c_data}, 32'h1234);
         chk("bp_c_src", {30'd0, c_src}, 32'd2);
         chk("bp_r_ready", {28'd0, r_ready}, 32'd0);
         next_cyc();
      end
      r_valid = 4'b0000; c_ready = 1'b1;
      next_cyc(); #1;
      chk("retire_c_valid", {31'd0, c_valid}, 32'd0);
      chk("retire_c_addr", {28'd0, c_addr}, 32'hA);

      // Lone requester 3, then wrap to 0.
      r_valid = 4'b1000; #1;
      chk("wrap_g3a", {28'd0, r_ready}, 32'h8);
      next_cyc(); #1;
      chk("wrap_g3b", {28'd0, r_ready}, 32'h8);
      next_cyc(); r_valid = 4'b1001; #1;
      chk("wrap_g0", {28'd0, r_ready}, 32'h1);
      next_cyc(); #1;
      chk("wrap_g3c", {28'd0, r_ready}, 32'h8);
      chk("wrap_src0", {30'd0, c_src}, 32'd0);
      next_cyc(); r_valid = 4'b0000; #1;
      chk("wrap_src3", {30'd0, c_src}, 32'd3);
      next_cyc();

      // Asynchronous reset while a word is stuck.
      r_valid = 4'b0100; c_ready = 1'b0;
      next_cyc(); r_valid = 4'b0000; #1;
      chk("ar_pre_valid", {31'd0, c_valid}, 32'd1);
      rst = 1'b1; #1;
      chk("ar_c_valid", {31'd0, c_valid}, 32'd0);
      chk("ar_c_addr", {28'd0, c_addr}, 32'd0);
      chk("ar_c_data", {18'd0, c_data}, 32'd0);
      chk("ar_c_src", {30'd0, c_src}, 32'd0);
      next_cyc(); rst = 1'b0; r_valid = 4'b1111; c_ready = 1'b1; #1;
      chk("ar_first_grant", {28'd0, r_ready}, 32'h1);
      next_cyc(); #1;
      chk("ar_first_src", {30'd0, c_src}, 32'd0);
      chk("ar_first_valid", {31'd0, c_valid}, 32'd1);

`ifdef CONF_ARB_COUNT_EN
      rst = 1'b1; next_cyc();
      rst = 1'b0; r_valid = 4'b0001; c_ready = 1'b1;
      repeat (65537) next_cyc();
      r_valid = 4'b0000;
      next_cyc(); #1;
      chk("count_wrap", {16'd0, c_count}, 32'd1);
      chk("count_idle", {31'd0, c_valid}, 32'd0);
`endif

      next_cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conf_arbiter.md
CONF_ARBITER -- requirements
Module: conf_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of configuration requesters, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 4: configuration address width.
REQ-003 SHALL have parameter DATA_W, default 14: configuration data width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-006 SHALL have port r_valid  input  NUM_REQ  per-requester write request.
REQ-007 SHALL have port r_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port r_data  input  NUM_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port r_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-010 SHALL have port c_ready  input  1  downstream configuration sink ready.
REQ-011 SHALL have port c_addr  output  ADDR_W  configuration address to sink.
REQ-012 SHALL have port c_data  output  DATA_W  configuration data to sink.
REQ-013 SHALL have port c_valid  output  1  configuration word valid.
REQ-014 SHALL have port c_src  output  $clog2(NUM_REQ)  index of requester owning the current c_addr/c_data.

Function
REQ-015 SHALL hold one output word in a register; state EMPTY (c_valid=0) or FULL (c_valid=1).
REQ-016 SHALL define accept = EMPTY or (FULL and c_ready).
REQ-017 SHALL, when accept and any r_valid is set, drive r_ready high combinationally for exactly one requester, chosen round-robin; r_ready is 0 otherwise.
REQ-018 SHALL search round-robin from index last+1 upward, wrapping modulo NUM_REQ; last = index of the most recently granted requester.
REQ-019 SHALL, on a posedge with r_valid[i] and r_ready[i], load r_addr/r_data slice i into c_addr/c_data, set c_src=i, set c_valid=1 and set last=i; latency is 1 cycle from handshake to c_valid.
REQ-020 SHALL keep c_addr, c_data and c_src stable while c_valid=1 and c_ready=0.
REQ-021 SHALL, on c_ready with c_valid=1 and no new handshake, clear c_valid (FULL->EMPTY) and keep c_addr/c_data/c_src at their last values.
REQ-022 SHALL, on c_ready and new handshake in the same cycle, replace the word with no bubble, sustaining 1 word/cycle.
REQ-023 SHALL ignore c_ready while EMPTY.
REQ-024 SHALL leave last unchanged in cycles without a handshake.
REQ-025 SHALL make r_ready independent of r_addr/r_data; it depends only on r_valid, state, c_ready and last.

Reset
REQ-026 SHALL, while rst=1, force c_valid=0, c_addr=0, c_data=0, c_src=0, state EMPTY, last=NUM_REQ-1 (requester 0 wins first), and r_ready=0.
REQ-027 SHALL discard any held word on rst asserted mid-transfer; no word is replayed after reset.
REQ-028 SHALL resume arbitration on the first posedge after rst deasserts.

Configuration
REQ-029 SHALL, with macro CONF_ARB_COUNT_EN defined, add output c_count (16 bits) that increments by 1 on every posedge with c_valid and c_ready, wraps 0xFFFF->0, and resets to 0.
REQ-030 SHALL, without CONF_ARB_COUNT_EN, omit port c_count and its register entirely; all other behaviour is identical.

Verification
REQ-031 SHALL cover: reset, r_valid=4'b1111 held, c_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, c_valid continuously 1 after the first cycle.
REQ-032 SHALL cover: requester 2 sends addr 4'hA, data 14'h1234; c_ready=0 for 5 cycles -> c_valid=1 with c_addr=4'hA, c_data=14'h1234, c_src=2 stable, all r_ready=0; c_ready=1 -> word retired, c_valid=0 the next cycle.
REQ-033 SHALL cover: only requester 3 valid twice, then requesters 0 and 3 valid -> grant 0 (wrap from last=3), then 3.
REQ-034 SHALL cover: rst pulsed while c_valid=1 and c_ready=0 -> c_valid=0, c_addr=0, c_data=0 immediately (asynchronously); first grant after release goes to requester 0.
REQ-035 SHALL cover: with CONF_ARB_COUNT_EN, 65537 completed transfers -> c_count=1; without the macro, the bench compiles with c_count unconnected and omitted.
